lzrw1_group_packer: RTL

Downstream of the compression core: serializes the compressed item stream (literals and copy items) into the byte-level LZRW1 output format. Items are gathered into groups of up to 16; each group is emitted as a 16-bit control word followed by the group's item bytes. A full group is buffered (at most 32 bytes) so the control word can precede its data, with valid/ready handshakes on both sides.

---
 rtl/lzrw1_group_packer_if.sv | 31 +++
 rtl/lzrw1_group_packer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/lzrw1_group_packer_if.sv
// Item-side and byte-side handshake bundle for the LZRW1 group packer.
// The master modport is the packer itself; the slave modport is its environment.
interface lzrw1_group_packer_if #(
  parameter int unsigned COUNTW = 16
);
  logic              item_valid;
  logic              item_ready;
  logic              item_is_copy;
  logic [7:0]        item_literal;
  logic [11:0]       item_offset;
  logic [3:0]        item_length;
  logic              item_last;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              out_last;
  logic              stream_done;
  logic [COUNTW-1:0] total_bytes;

  modport master (
    input  item_valid, item_is_copy, item_literal, item_offset, item_length, item_last,
    input  out_ready,
    output item_ready, out_valid, out_byte, out_last, stream_done, total_bytes
  );

  modport slave (
    output item_valid, item_is_copy, item_literal, item_offset, item_length, item_last,
    output out_ready,
    input  item_ready, out_valid, out_byte, out_last, stream_done, total_bytes
  );
endinterface

// File: rtl/lzrw1_group_packer.sv
// Gathers LZRW1 items into groups of up to 16 and emits each group as a 16-bit
// control word (low byte first) followed by the buffered item bytes.
module lzrw1_group_packer #(
  parameter int unsigned COUNTW = 16
) (
  input logic                  clock,
  input logic                  reset,
  lzrw1_group_packer_if.master bus
);
  typedef enum logic [1:0] {StCollect, StCtrlLo, StCtrlHi, StData} state_e;

  state_e            state_q;
  logic [7:0]        data_buf [32];
  logic [15:0]       ctrl_q;
  logic [5:0]        wr_ptr_q;
  logic [5:0]        rd_ptr_q;
  logic [4:0]        item_cnt_q;
  logic              grp_last_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              stream_done_q;
  logic [7:0]        out_byte_q;
  logic [COUNTW-1:0] total_q;

  logic        accept;
  logic        handshake;
  logic        closing;
  logic        data_end;
  logic [15:0] ctrl_next;
  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic [5:0]  wr_ptr_next;
  logic [5:0]  rd_ptr_inc;

  // item_ready is decoded straight from state so the producer sees it without a cycle lag.
  assign bus.item_ready  = (state_q == StCollect) && !reset;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_byte    = out_byte_q;
  assign bus.out_last    = out_last_q;
  assign bus.stream_done = stream_done_q;
  assign bus.total_bytes = total_q;

  always_comb begin
    accept      = bus.item_valid && bus.item_ready;
    handshake   = out_valid_q && bus.out_ready;
    ctrl_next   = ctrl_q | (16'(bus.item_is_copy) << item_cnt_q[3:0]);
    byte0       = bus.item_is_copy ? {bus.item_offset[11:8], bus.item_length} : bus.item_literal;
    byte1       = bus.item_offset[7:0];
    wr_ptr_next = wr_ptr_q + (bus.item_is_copy ? 6'd2 : 6'd1);
    closing     = accept && ((item_cnt_q == 5'd15) || bus.item_last);
    rd_ptr_inc  = rd_ptr_q + 6'd1;
    data_end    = (rd_ptr_inc == wr_ptr_q);
  end

  // A full group of 16 copies fills exactly 32 bytes, so 5 index bits suffice.
  always_ff @(posedge clock) begin
    if (accept) begin
      data_buf[wr_ptr_q[4:0]] <= byte0;
      if (bus.item_is_copy) begin
        data_buf[wr_ptr_q[4:0] + 5'd1] <= byte1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StCollect;
      ctrl_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      item_cnt_q    <= '0;
      grp_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      stream_done_q <= 1'b0;
      out_byte_q    <= '0;
      total_q       <= '0;
    end else begin
      stream_done_q <= 1'b0;
      if (handshake) begin
        total_q <= total_q + COUNTW'(1);
      end
      unique case (state_q)
        StCollect: begin
          if (accept) begin
            ctrl_q     <= ctrl_next;
            wr_ptr_q   <= wr_ptr_next;
            item_cnt_q <= item_cnt_q + 5'd1;
            if (closing) begin
              state_q     <= StCtrlLo;
              grp_last_q  <= bus.item_last;
              out_valid_q <= 1'b1;
              out_byte_q  <= ctrl_next[7:0];
              out_last_q  <= 1'b0;
            end
          end
        end
        StCtrlLo: begin
          if (handshake) begin
            state_q    <= StCtrlHi;
            out_byte_q <= ctrl_q[15:8];
          end
        end
        StCtrlHi: begin
          if (handshake) begin
            state_q    <= StData;
            rd_ptr_q   <= '0;
            out_byte_q <= data_buf[0];
            out_last_q <= grp_last_q && (wr_ptr_q == 6'd1);
          end
        end
        StData: begin
          if (handshake) begin
            if (data_end) begin
              state_q       <= StCollect;
              out_valid_q   <= 1'b0;
              out_last_q    <= 1'b0;
              stream_done_q <= out_last_q;
              ctrl_q        <= '0;
              wr_ptr_q      <= '0;
              rd_ptr_q      <= '0;
              item_cnt_q    <= '0;
            end else begin
              rd_ptr_q   <= rd_ptr_inc;
              out_byte_q <= data_buf[rd_ptr_inc[4:0]];
              out_last_q <= grp_last_q && ((rd_ptr_q + 6'd2) == wr_ptr_q);
            end
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end
endmodule
